// File: rtl/pipelined_adder_if.sv
// Operand and result streams of the pipelined adder/subtractor.
//
// Both streams use the same valid/ready rule: the producer raises valid
// with its data, keeps data stable until the beat is taken, and a beat
// transfers on exactly those rising clock edges where valid && ready.
// ready may depend combinationally on the consumer's state.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Upstream/downstream side: drives operands, consumes results.
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor. A WIDTH-bit operation is cut
// into STAGES slices of CHUNK bits; stage k ripples slice k using the
// carry registered by stage k-1. Unconsumed operand bits travel forward
// in shrinking skew registers and finished low sum bits travel forward in
// growing registers, so a beat's result leaves the last stage whole.
// Every stage advances on the same global enable (stall when the output
// holds a result the consumer is refusing).
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic              clk,
    input logic              rst_n,
    pipelined_adder_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;

    logic en;
    logic accept;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // REM: operand bits entering this stage; DONE: sum bits leaving it.
        localparam int REM  = WIDTH - k * CHUNK;
        localparam int DONE = (k + 1) * CHUNK;

        logic [REM-1:0]   a_d;
        logic [REM-1:0]   b_d;
        logic             c_d;
        logic             sub_d;
        logic             asg_d;
        logic             bsg_d;
        logic             vld_d;
        logic [CHUNK-1:0] slice;
        logic             c_nx;
        logic [DONE-1:0]  s_nx;

        logic             vld_q;
        logic             c_q;
        logic             sub_q;
        logic             asg_q;
        logic             bsg_q;
        logic [DONE-1:0]  s_q;

        if (k == 0) begin : g_head
            // Subtract is a + ~b + !cin: invert b and the slice-0 carry here.
            assign a_d   = bus.a;
            assign b_d   = bus.sub ? ~bus.b : bus.b;
            assign c_d   = bus.cin ^ bus.sub;
            assign sub_d = bus.sub;
            assign asg_d = bus.a[WIDTH-1];
            assign bsg_d = b_d[WIDTH-1];
            assign vld_d = accept;
            assign s_nx  = slice;
        end else begin : g_body
            assign a_d   = g_stage[k-1].g_skew.a_q;
            assign b_d   = g_stage[k-1].g_skew.b_q;
            assign c_d   = g_stage[k-1].c_q;
            assign sub_d = g_stage[k-1].sub_q;
            assign asg_d = g_stage[k-1].asg_q;
            assign bsg_d = g_stage[k-1].bsg_q;
            assign vld_d = g_stage[k-1].vld_q;
            assign s_nx  = {slice, g_stage[k-1].s_q};
        end

        // One CHUNK-bit ripple-carry chain on the lowest unconsumed slice.
        always_comb begin
            logic rc;
            rc    = c_d;
            slice = '0;
            for (int i = 0; i < CHUNK; i++) begin
                slice[i] = a_d[i] ^ b_d[i] ^ rc;
                rc       = (a_d[i] & b_d[i]) | (rc & (a_d[i] ^ b_d[i]));
            end
            c_nx = rc;
        end

        // Stage register: valid, carry, beat attributes and finished sum bits.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                sub_q <= 1'b0;
                asg_q <= 1'b0;
                bsg_q <= 1'b0;
                s_q   <= '0;
            end else if (en) begin
                vld_q <= vld_d;
                c_q   <= c_nx;
                sub_q <= sub_d;
                asg_q <= asg_d;
                bsg_q <= bsg_d;
                s_q   <= s_nx;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [REM-CHUNK-1:0] a_q;
            logic [REM-CHUNK-1:0] b_q;

            // Skew registers carry the operand slices later stages still need.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_d[REM-1:CHUNK];
                    b_q <= b_d[REM-1:CHUNK];
                end
            end
        end
    end

    // Global stall: only a refused result at the output freezes the pipe.
    assign en           = !(g_stage[STAGES-1].vld_q && !bus.out_ready);
    assign bus.in_ready = en;
    assign accept       = bus.in_valid && en;

    assign bus.out_valid = g_stage[STAGES-1].vld_q;
    assign bus.sum       = g_stage[STAGES-1].s_q;
    // In subtract mode the final carry means "no borrow", so invert it.
    assign bus.cout      = g_stage[STAGES-1].c_q ^ g_stage[STAGES-1].sub_q;
    assign bus.ovf       = (g_stage[STAGES-1].asg_q == g_stage[STAGES-1].bsg_q) &&
                           (g_stage[STAGES-1].s_q[WIDTH-1] != g_stage[STAGES-1].asg_q);
endmodule
